// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 1024x768@60 raster constants for the VGA sync generator and peripheral
package vga_pkg;

    function automatic int axis_total(int active, int front, int sync, int back);
        return active + front + sync + back;
    endfunction

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FRONT  = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BACK   = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FRONT  = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BACK   = 29;

    localparam int H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    localparam int X_W = 11;
    localparam int Y_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with registered sync/active decode
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE      = DEF_H_ACTIVE,
    parameter int FRONT       = DEF_H_FRONT,
    parameter int SYNC        = DEF_H_SYNC,
    parameter int BACK        = DEF_H_BACK,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int W           = X_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] pos,
    output logic         sync,
    output logic         active,
    output logic         wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FRONT + SYNC);

    logic [W-1:0] pos_next;

    always_comb begin
        wrap     = advance && (pos == LAST);
        pos_next = pos;
        if (wrap) begin
            pos_next = '0;
        end else if (advance) begin
            pos_next = pos + W'(1);
        end
    end

    // Decode from pos_next so sync/active land in the same cycle as the position they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos    <= '0;
            sync   <= ~SYNC_ACTIVE;
            active <= 1'b1;
        end else begin
            pos    <= pos_next;
            sync   <= (pos_next >= SYNC_START && pos_next < SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            active <= (pos_next < ACTIVE_END);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster timing generator with frame counter and sticky vblank interrupt
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cli,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic [7:0]     frame,
    output logic           interrupt
);

    localparam logic [Y_W-1:0] LAST_ACTIVE_LINE = Y_W'(V_ACTIVE - 1);

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;
    logic irq_set;

    vga_axis_counter #(
        .ACTIVE     (H_ACTIVE),
        .FRONT      (H_FRONT),
        .SYNC       (H_SYNC),
        .BACK       (H_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE),
        .W          (X_W)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .advance(1'b1),
        .pos    (x),
        .sync   (hsync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE     (V_ACTIVE),
        .FRONT      (V_FRONT),
        .SYNC       (V_SYNC),
        .BACK       (V_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE),
        .W          (Y_W)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .advance(h_wrap),
        .pos    (y),
        .sync   (vsync),
        .active (v_active),
        .wrap   (v_wrap)
    );

    assign blank = ~(h_active & v_active);

    // The edge leaving the last active line lands on (0, V_ACTIVE): first clock of vertical blank.
    assign irq_set = h_wrap && (y == LAST_ACTIVE_LINE);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame     <= 8'd0;
            interrupt <= 1'b0;
        end else begin
            if (h_wrap && v_wrap) begin
                frame <= frame + 8'd1;
            end
            if (irq_set) begin
                interrupt <= 1'b1;
            end else if (cli) begin
                interrupt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench: four raster instances against an arithmetic timing model
module tb_vga_sync_gen;

    // Instances: 0 default, 1 default positive sync, 2 mid-size, 3 tiny (frame wrap)
    localparam int P_HA[4] = '{1024, 1024, 16, 8};
    localparam int P_HF[4] = '{24, 24, 2, 2};
    localparam int P_HS[4] = '{136, 136, 4, 2};
    localparam int P_HB[4] = '{160, 160, 2, 2};
    localparam int P_VA[4] = '{768, 768, 12, 4};
    localparam int P_VF[4] = '{3, 3, 3, 1};
    localparam int P_VS[4] = '{6, 6, 6, 1};
    localparam int P_VB[4] = '{29, 29, 4, 1};
    localparam int P_SA[4] = '{0, 1, 0, 0};

    logic        clk;
    logic        rst;
    logic        cli;
    logic [10:0] ax[4];
    logic [9:0]  ay[4];
    logic        ahs[4];
    logic        avs[4];
    logic        abl[4];
    logic [7:0]  afr[4];
    logic        aint[4];

    longint t;
    bit     m_int[4];
    int     n_tests;
    int     n_fail;

    vga_sync_gen u_d0 (
        .clk(clk), .rst(rst), .cli(cli), .x(ax[0]), .y(ay[0]), .hsync(ahs[0]),
        .vsync(avs[0]), .blank(abl[0]), .frame(afr[0]), .interrupt(aint[0])
    );

    vga_sync_gen #(.SYNC_ACTIVE(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .cli(cli), .x(ax[1]), .y(ay[1]), .hsync(ahs[1]),
        .vsync(avs[1]), .blank(abl[1]), .frame(afr[1]), .interrupt(aint[1])
    );

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(6), .V_BACK(4)
    ) u_dm (
        .clk(clk), .rst(rst), .cli(cli), .x(ax[2]), .y(ay[2]), .hsync(ahs[2]),
        .vsync(avs[2]), .blank(abl[2]), .frame(afr[2]), .interrupt(aint[2])
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_dr (
        .clk(clk), .rst(rst), .cli(cli), .x(ax[3]), .y(ay[3]), .hsync(ahs[3]),
        .vsync(avs[3]), .blank(abl[3]), .frame(afr[3]), .interrupt(aint[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Position after tt pixel clocks from the top-left, straight from the mode arithmetic.
    function automatic void model_pos(input int i, input longint tt,
                                      output int ex, output int ey, output int ef,
                                      output int ehs, output int evs, output int ebl);
        longint ht, vt, line;
        ht   = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt   = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        ex   = int'(tt % ht);
        line = tt / ht;
        ey   = int'(line % vt);
        ef   = int'((line / vt) % 256);
        ehs  = (ex >= P_HA[i] + P_HF[i] && ex < P_HA[i] + P_HF[i] + P_HS[i]) ? P_SA[i] : 1 - P_SA[i];
        evs  = (ey >= P_VA[i] + P_VF[i] && ey < P_VA[i] + P_VF[i] + P_VS[i]) ? P_SA[i] : 1 - P_SA[i];
        ebl  = (ex >= P_HA[i] || ey >= P_VA[i]) ? 1 : 0;
    endfunction

    task automatic step();
        int ex, ey, ef, ehs, evs, ebl;
        @(posedge clk);
        #1;
        if (rst) t = 0;
        else t++;
        for (int i = 0; i < 4; i++) begin
            model_pos(i, t, ex, ey, ef, ehs, evs, ebl);
            if (rst) m_int[i] = 1'b0;
            else if (ex == 0 && ey == P_VA[i]) m_int[i] = 1'b1;
            else if (cli) m_int[i] = 1'b0;
            chk($sformatf("x[%0d]", i), ax[i], ex);
            chk($sformatf("y[%0d]", i), ay[i], ey);
            chk($sformatf("frame[%0d]", i), afr[i], ef);
            chk($sformatf("hsync[%0d]", i), ahs[i], ehs);
            chk($sformatf("vsync[%0d]", i), avs[i], evs);
            chk($sformatf("blank[%0d]", i), abl[i], ebl);
            chk($sformatf("interrupt[%0d]", i), aint[i], m_int[i]);
        end
    endtask

    task automatic run_to(input longint target);
        int guard;
        guard = 0;
        while (t < target && guard < 60000) begin
            step();
            guard++;
        end
        chk("run_to", t, target);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        t       = 0;
        rst     = 1'b1;
        cli     = 1'b0;
        for (int i = 0; i < 4; i++) m_int[i] = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        run_to(2000);

        // Mid-frame reset, held for three clocks
        rst = 1'b1;
        repeat (3) step();
        chk("reset x", ax[0], 0);
        chk("reset y", ay[0], 0);
        chk("reset hsync", ahs[0], 1);
        chk("reset vsync", avs[0], 1);
        chk("reset blank", abl[0], 0);
        chk("reset frame", afr[0], 0);
        chk("reset interrupt mid", aint[2], 0);
        chk("reset hsync pos", ahs[1], 0);
        chk("reset vsync pos", avs[1], 0);
        rst = 1'b0;
        step();
        chk("first x after reset", ax[0], 1);

        // Mid-size instance: interrupt set, cli pulse, vsync window, frame rollover
        run_to(287);
        chk("irq before vblank", aint[2], 0);
        run_to(288);
        chk("irq set x", ax[2], 0);
        chk("irq set y", ay[2], 12);
        chk("irq set blank", abl[2], 1);
        chk("irq set", aint[2], 1);
        run_to(346);
        chk("irq held", aint[2], 1);
        cli = 1'b1;
        step();
        chk("irq cleared", aint[2], 0);
        cli = 1'b0;
        run_to(359);
        chk("vsync before window", avs[2], 1);
        run_to(360);
        chk("vsync window start", avs[2], 0);
        run_to(503);
        chk("vsync window end", avs[2], 0);
        run_to(504);
        chk("vsync after window", avs[2], 1);
        run_to(599);
        chk("last x", ax[2], 23);
        chk("last y", ay[2], 24);
        chk("frame before wrap", afr[2], 0);
        run_to(600);
        chk("wrap x", ax[2], 0);
        chk("wrap y", ay[2], 0);
        chk("frame inc", afr[2], 1);
        run_to(887);
        chk("irq stays low", aint[2], 0);
        run_to(888);
        chk("irq set again", aint[2], 1);

        // Default instance, line 0 horizontal timing
        run_to(1023);
        chk("blank at 1023", abl[0], 0);
        run_to(1024);
        chk("blank at 1024", abl[0], 1);
        run_to(1047);
        chk("hsync at 1047", ahs[0], 1);
        chk("pos hsync at 1047", ahs[1], 0);
        run_to(1048);
        chk("hsync at 1048", ahs[0], 0);
        chk("pos hsync at 1048", ahs[1], 1);
        run_to(1183);
        chk("hsync at 1183", ahs[0], 0);
        run_to(1184);
        chk("hsync at 1184", ahs[0], 1);
        chk("pos hsync at 1184", ahs[1], 0);
        run_to(1343);
        chk("x at line end", ax[0], 1343);
        chk("y at line end", ay[0], 0);
        run_to(1344);
        chk("x after line wrap", ax[0], 0);
        chk("y after line wrap", ay[0], 1);

        // Collision: cli held across the set event
        run_to(1480);
        cli = 1'b1;
        run_to(1487);
        chk("collision pre", aint[2], 0);
        run_to(1488);
        chk("collision set wins", aint[2], 1);
        step();
        chk("collision drop", aint[2], 0);
        cli = 1'b0;

        // Tiny instance: 256 frames of 98 clocks
        run_to(25087);
        chk("tiny frame 255", afr[3], 255);
        run_to(25088);
        chk("tiny frame wrap", afr[3], 0);
        chk("tiny x wrap", ax[3], 0);
        chk("tiny y wrap", ay[3], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
